// File: rtl/mips_program_loader.sv
// Boot-time program loader: turns a valid/ready byte stream into big-endian
// 32-bit instruction words and writes them to instruction memory. The MIPS
// core is held in reset until the image has been written.
module mips_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        DONE,
        RUN,
        ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       CAPACITY = 17'(1) << ADDR_W;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;      // byte position within header or word
    logic [7:0]  hdr_hi;        // first header byte, N[15:8]
    logic [15:0] word_count;    // N from the header
    logic [23:0] asm_word;      // first three bytes of the word in progress
    logic        xfer;
    logic        last_word;
    logic [15:0] hdr_count;

    assign xfer      = byte_valid & byte_ready;
    assign hdr_count = {hdr_hi, byte_data};
    assign last_word = (words_loaded + 16'd1) == word_count;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        cpu_reset  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                byte_ready = 1'b1;
                if (xfer && byte_cnt == 2'd1) begin
                    // An empty image has nothing to flush, so the core is
                    // released on the very next edge by skipping DONE.
                    if (hdr_count == 16'd0) begin
                        state_next = RUN;
                    end else if ({1'b0, hdr_count} > CAPACITY) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (xfer && byte_cnt == 2'd3 && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = RUN;
            end
            RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
                if (start) begin
                    state_next = HDR;
                end
            end
            ERR: begin
                load_error = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Header capture, word assembly and memory write port
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt     <= 2'd0;
            hdr_hi       <= 8'd0;
            word_count   <= 16'd0;
            asm_word     <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if ((state == IDLE || state == RUN) && start) begin
                byte_cnt     <= 2'd0;
                words_loaded <= 16'd0;
            end else if (xfer && state == HDR) begin
                hdr_hi <= byte_data;
                if (byte_cnt == 2'd1) begin
                    word_count <= hdr_count;
                    byte_cnt   <= 2'd0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (xfer && state == LOAD) begin
                asm_word <= {asm_word[15:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    imem_we      <= 1'b1;
                    imem_wdata   <= {asm_word, byte_data};
                    imem_addr    <= BASE + words_loaded[ADDR_W-1:0];
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader (ADDR_W=8, BASE_ADDR=0).
module tb_mips_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;
    int wr_n = 0;
    int wr_base;
    int gap_bad;
    logic [7:0]  wr_addr [16];
    logic [31:0] wr_data [16];

    logic [7:0] img1 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h20, 8'h09, 8'h00, 8'h07};
    logic [7:0] img5 [6]  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] img6 [6]  = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    mips_program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every memory write strobe
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    // Hard stop if the run never finishes
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({pfx, "_imem_we"}, 32'(imem_we), 32'd0);
        check({pfx, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({pfx, "_imem_wdata"}, imem_wdata, 32'd0);
        check({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({pfx, "_load_done"}, 32'(load_done), 32'd0);
        check({pfx, "_load_error"}, 32'(load_error), 32'd0);
        check({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one byte, wait (bounded) for ready, hand it over on the next
    // edge and return 1 time unit after that edge; then idle for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 32'(byte_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'hXX;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (!byte_ready) gap_bad = gap_bad + 1;
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_vals("rst");
        release_reset();

        // Image of two words, continuous stream
        wr_base = wr_n;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(img1[i], 0);
            if (i == 5) begin
                check("t1_we_pulse", 32'(imem_we), 32'd1);
                check("t1_we_addr", 32'(imem_addr), 32'd0);
                check("t1_we_data", imem_wdata, 32'h20080005);
            end
        end
        check("t1_cpu_reset_e1", 32'(cpu_reset), 32'd1);
        check("t1_ready_done", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t1_cpu_reset_e2", 32'(cpu_reset), 32'd0);
        check("t1_load_done", 32'(load_done), 32'd1);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_nwr", 32'(wr_n - wr_base), 32'd2);
        check("t1_a0", 32'(wr_addr[wr_base]), 32'd0);
        check("t1_d0", wr_data[wr_base], 32'h20080005);
        check("t1_a1", 32'(wr_addr[wr_base+1]), 32'd1);
        check("t1_d1", wr_data[wr_base+1], 32'h20090007);

        // Same image with 5-cycle gaps after every byte
        do_reset();
        release_reset();
        wr_base = wr_n;
        gap_bad = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(img1[i], (i == 9) ? 0 : 5);
        end
        check("t2_cpu_reset_e1", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        #1;
        check("t2_cpu_reset_e2", 32'(cpu_reset), 32'd0);
        check("t2_load_done", 32'(load_done), 32'd1);
        check("t2_words", 32'(words_loaded), 32'd2);
        check("t2_ready_in_gaps", 32'(gap_bad), 32'd0);
        check("t2_nwr", 32'(wr_n - wr_base), 32'd2);
        check("t2_a0", 32'(wr_addr[wr_base]), 32'd0);
        check("t2_d0", wr_data[wr_base], 32'h20080005);
        check("t2_a1", 32'(wr_addr[wr_base+1]), 32'd1);
        check("t2_d1", wr_data[wr_base+1], 32'h20090007);

        // Empty image
        do_reset();
        release_reset();
        wr_base = wr_n;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t3_cpu_reset_e1", 32'(cpu_reset), 32'd0);
        check("t3_load_done", 32'(load_done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_nwr", 32'(wr_n - wr_base), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd0);

        // Oversized header: 257 words into a 256-word memory
        do_reset();
        release_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("t4_error", 32'(load_error), 32'd1);
        check("t4_ready", 32'(byte_ready), 32'd0);
        check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        check("t4_error_after_start", 32'(load_error), 32'd1);
        check("t4_ready_after_start", 32'(byte_ready), 32'd0);
        do_reset();
        check("t4_error_cleared", 32'(load_error), 32'd0);
        release_reset();

        // Reset in the middle of word 0, then a clean reload
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(img5[i], 0);
        do_reset();
        check_reset_vals("t5_midrst");
        release_reset();
        wr_base = wr_n;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img5[i], 0);
        @(posedge clk);
        #1;
        check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t5_nwr", 32'(wr_n - wr_base), 32'd1);
        check("t5_a0", 32'(wr_addr[wr_base]), 32'd0);
        check("t5_d0", wr_data[wr_base], 32'hDEADBEEF);

        // Restart from RUN
        wr_base = wr_n;
        pulse_start();
        check("t6_cpu_reset_restart", 32'(cpu_reset), 32'd1);
        check("t6_load_done_restart", 32'(load_done), 32'd0);
        check("t6_words_cleared", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 6; i++) send_byte(img6[i], 0);
        check("t6_cpu_reset_e1", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        #1;
        check("t6_cpu_reset_e2", 32'(cpu_reset), 32'd0);
        check("t6_load_done", 32'(load_done), 32'd1);
        check("t6_nwr", 32'(wr_n - wr_base), 32'd1);
        check("t6_a0", 32'(wr_addr[wr_base]), 32'd0);
        check("t6_d0", wr_data[wr_base], 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
